pid_channel_scheduler: RTL and testbench

Time-multiplexes one shared PID arithmetic step across `NCH` control channels. Each sample request is arbitrated round-robin. The block owns per-channel gains and loop state (integral, previous error), sequences the shared `pid_step` datapath and publishes a clamped 8-bit control value per channel. It sits between the sensor/setpoint front-end and the actuator output registers, replacing one PID instance per loop.

---
 rtl/pid_channel_scheduler_pkg.sv | 37 +++
 rtl/pid_channel_scheduler_step.sv | 45 ++++
 rtl/pid_channel_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_pid_channel_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_channel_scheduler_pkg.sv
// Shared types and constants for the multiplexed PID scheduler and its
// arithmetic step.
package pid_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        WRITE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_KP   = 2'd0,
        SEL_KI   = 2'd1,
        SEL_KD   = 2'd2,
        SEL_NONE = 2'd3
    } gain_sel_t;

    localparam int ERR_W   = 9;
    localparam int INTEG_W = 16;
    localparam int SUM_W   = 20;

    localparam logic [7:0] KP_RST = 8'd1;
    localparam logic [7:0] KI_RST = 8'd0;
    localparam logic [7:0] KD_RST = 8'd0;

    // Negative sums map to 0, anything above 255 to 255.
    function automatic logic [7:0] clamp_u8(input logic signed [SUM_W-1:0] u);
        if (u[SUM_W-1])
            return 8'd0;
        else if (u > 20'sd255)
            return 8'd255;
        else
            return u[7:0];
    endfunction

endpackage

// File: rtl/pid_channel_scheduler_step.sv
// Combinational PID arithmetic for one sample: error, saturated integral and
// the unclamped control sum.
module pid_step
    import pid_pkg::*;
(
    input  logic        [7:0]         sp,
    input  logic        [7:0]         fb,
    input  logic        [7:0]         kp,
    input  logic        [7:0]         ki,
    input  logic        [7:0]         kd,
    input  logic signed [INTEG_W-1:0] integ,
    input  logic signed [ERR_W-1:0]   prev,
    output logic signed [ERR_W-1:0]   e,
    output logic signed [INTEG_W-1:0] integ_next,
    output logic signed [SUM_W-1:0]   u
);

    // 19 bits hold integ + Ki*e (at most +/-97793) before saturation.
    localparam int ACC_W = 19;
    localparam logic signed [ACC_W-1:0] SAT_HI = 19'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_LO = -19'sd32768;

    logic signed [ACC_W-1:0] ki_term;
    logic signed [ACC_W-1:0] acc;
    logic signed [ERR_W:0]   de;
    logic signed [SUM_W-1:0] p_term;
    logic signed [SUM_W-1:0] d_term;

    always_comb begin
        e       = $signed({1'b0, sp}) - $signed({1'b0, fb});
        ki_term = ACC_W'($signed({1'b0, ki})) * ACC_W'(e);
        acc     = ACC_W'(integ) + ki_term;
        if (acc > SAT_HI)
            integ_next = 16'sh7fff;
        else if (acc < SAT_LO)
            integ_next = 16'sh8000;
        else
            integ_next = acc[INTEG_W-1:0];
        de     = (ERR_W+1)'(e) - (ERR_W+1)'(prev);
        d_term = SUM_W'($signed({1'b0, kd})) * SUM_W'(de);
        p_term = SUM_W'($signed({1'b0, kp})) * SUM_W'(e);
        u      = p_term + SUM_W'(integ_next) + d_term;
    end

endmodule

// File: rtl/pid_channel_scheduler.sv
// Round-robin scheduler that time-shares one pid_step across NCH loops and
// owns per-channel gains, integral, previous error and published outputs.
module pid_channel_scheduler
    import pid_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req,
    input  logic [8*NCH-1:0]  setpoint,
    input  logic [8*NCH-1:0]  feedback,
    output logic [NCH-1:0]    ack,
    input  logic [NCH-1:0]    chan_clr,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [1:0]        cfg_sel,
    input  logic [7:0]        cfg_data,
    output logic              out_valid,
    output logic [2:0]        out_ch,
    output logic [7:0]        out_data,
    output logic [8*NCH-1:0]  ctrl,
    output logic              busy
);

    localparam int CHI = (NCH > 1) ? $clog2(NCH) : 1;

    state_t                    state;
    logic [CHI-1:0]            last;
    logic [CHI-1:0]            g;
    logic [NCH-1:0]            g_oh;
    logic                      clr_pend;
    logic [CHI-1:0]            grant_ch;
    logic [NCH-1:0]            grant_oh;
    logic                      found;
    logic [CHI:0]              cand;
    logic                      clr_hit;
    logic                      cfg_ok;
    logic [CHI-1:0]            cfg_idx;

    logic [7:0]                sp_arr [NCH];
    logic [7:0]                fb_arr [NCH];
    logic [7:0]                kp_q   [NCH];
    logic [7:0]                ki_q   [NCH];
    logic [7:0]                kd_q   [NCH];
    logic [7:0]                ctrl_q [NCH];
    logic signed [INTEG_W-1:0] integ_q [NCH];
    logic signed [ERR_W-1:0]   prev_q  [NCH];

    logic [7:0]                sp_c, fb_c, kp_c, ki_c, kd_c;
    logic signed [INTEG_W-1:0] integ_c, res_integ, step_integ;
    logic signed [ERR_W-1:0]   prev_c, res_e, step_e;
    logic signed [SUM_W-1:0]   step_u;
    logic [7:0]                u_clamped;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        assign sp_arr[c]          = setpoint[c*8 +: 8];
        assign fb_arr[c]          = feedback[c*8 +: 8];
        assign ctrl[c*8 +: 8]     = ctrl_q[c];
    end

    assign clr_hit   = |(chan_clr & g_oh);
    assign cfg_ok    = cfg_we && ({1'b0, cfg_ch} < 4'(NCH));
    assign cfg_idx   = CHI'(cfg_ch);
    assign u_clamped = clamp_u8(step_u);

    // Search starts just after the last granted channel and wraps at NCH.
    always_comb begin
        // NOTE: every variable gets a default first so no path holds a value (no latch).
        found    = 1'b0;
        grant_oh = '0;
        grant_ch = '0;
        cand     = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = {1'b0, last} + (CHI+1)'(i);
            if (cand >= (CHI+1)'(NCH))
                cand = cand - (CHI+1)'(NCH);
            if (!found && req[cand[CHI-1:0]]) begin
                found                   = 1'b1;
                grant_oh[cand[CHI-1:0]] = 1'b1;
                grant_ch                = cand[CHI-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the gain file is reset because its reset values are architectural.
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                kp_q[c] <= KP_RST;
                ki_q[c] <= KI_RST;
                kd_q[c] <= KD_RST;
            end
        end else if (cfg_ok) begin
            case (gain_sel_t'(cfg_sel))
                SEL_KP:  kp_q[cfg_idx] <= cfg_data;
                SEL_KI:  ki_q[cfg_idx] <= cfg_data;
                SEL_KD:  kd_q[cfg_idx] <= cfg_data;
                default: ;
            endcase
        end
    end

    pid_step u_step (
        .sp         (sp_c),
        .fb         (fb_c),
        .kp         (kp_c),
        .ki         (ki_c),
        .kd         (kd_c),
        .integ      (integ_c),
        .prev       (prev_c),
        .e          (step_e),
        .integ_next (step_integ),
        .u          (step_u)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= CHI'(NCH-1);
            g         <= '0;
            g_oh      <= '0;
            clr_pend  <= 1'b0;
            ack       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            sp_c      <= '0;
            fb_c      <= '0;
            kp_c      <= '0;
            ki_c      <= '0;
            kd_c      <= '0;
            integ_c   <= '0;
            prev_c    <= '0;
            res_integ <= '0;
            res_e     <= '0;
            for (int c = 0; c < NCH; c++) begin
                integ_q[c] <= '0;
                prev_q[c]  <= '0;
                ctrl_q[c]  <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout so every branch reads pre-edge state.
            ack       <= '0;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        ack      <= grant_oh;
                        g        <= grant_ch;
                        g_oh     <= grant_oh;
                        last     <= grant_ch;
                        clr_pend <= 1'b0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    sp_c     <= sp_arr[g];
                    fb_c     <= fb_arr[g];
                    kp_c     <= kp_q[g];
                    ki_c     <= ki_q[g];
                    kd_c     <= kd_q[g];
                    integ_c  <= integ_q[g];
                    prev_c   <= prev_q[g];
                    clr_pend <= clr_pend | clr_hit;
                    state    <= COMPUTE;
                end
                COMPUTE: begin
                    res_integ <= step_integ;
                    res_e     <= step_e;
                    out_valid <= 1'b1;
                    out_ch    <= 3'(g);
                    out_data  <= u_clamped;
                    ctrl_q[g] <= u_clamped;
                    clr_pend  <= clr_pend | clr_hit;
                    state     <= WRITE;
                end
                WRITE: begin
                    if (!clr_pend) begin
                        integ_q[g] <= res_integ;
                        prev_q[g]  <= res_e;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A clear issued late in the block wins over the write-back above.
            for (int c = 0; c < NCH; c++) begin
                if (chan_clr[c]) begin
                    integ_q[c] <= '0;
                    prev_q[c]  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a timestamp-based model.
module tb_pid_channel_scheduler;

    localparam int NCH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NCH-1:0]   req;
    logic [8*NCH-1:0] setpoint;
    logic [8*NCH-1:0] feedback;
    logic [NCH-1:0]   ack;
    logic [NCH-1:0]   chan_clr;
    logic             cfg_we;
    logic [2:0]       cfg_ch;
    logic [1:0]       cfg_sel;
    logic [7:0]       cfg_data;
    logic             out_valid;
    logic [2:0]       out_ch;
    logic [7:0]       out_data;
    logic [8*NCH-1:0] ctrl;
    logic             busy;

    pid_channel_scheduler #(.NCH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .setpoint  (setpoint),
        .feedback  (feedback),
        .ack       (ack),
        .chan_clr  (chan_clr),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .ctrl      (ctrl),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int tb_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: loop state as plain integers, sequencing by edge timestamps.
    int m_kp [NCH], m_ki [NCH], m_kd [NCH];
    int m_integ [NCH], m_prev [NCH], m_ctrl [NCH];
    int m_last, cyc, gedge, mg;
    int r_integ, r_e, r_out;
    bit r_clr;
    int x_ack, x_valid, x_out_ch, x_out_data, x_busy;

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int clamp8(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_kp[c] = 1; m_ki[c] = 0; m_kd[c] = 0;
            m_integ[c] = 0; m_prev[c] = 0; m_ctrl[c] = 0;
        end
        m_last = NCH - 1; cyc = 0; gedge = -100; mg = 0; r_clr = 0;
        x_ack = 0; x_valid = 0; x_out_ch = 0; x_out_data = 0; x_busy = 0;
    endtask

    task automatic model_step();
        int e, ip, d, u;
        bit found;
        cyc++;
        x_ack = 0;
        x_valid = 0;
        if (cyc == gedge + 1) begin
            e  = int'(setpoint[mg*8 +: 8]) - int'(feedback[mg*8 +: 8]);
            ip = sat16(m_integ[mg] + m_ki[mg] * e);
            d  = m_kd[mg] * (e - m_prev[mg]);
            u  = m_kp[mg] * e + ip + d;
            r_integ = ip; r_e = e; r_out = clamp8(u);
            r_clr = chan_clr[mg];
        end else if (cyc == gedge + 2) begin
            x_valid = 1; x_out_ch = mg; x_out_data = r_out;
            m_ctrl[mg] = r_out;
            r_clr = r_clr | chan_clr[mg];
        end else if (cyc == gedge + 3) begin
            if (!r_clr) begin
                m_integ[mg] = r_integ;
                m_prev[mg]  = r_e;
            end
        end else if (req != '0) begin
            found = 0;
            for (int i = 1; i <= NCH; i++) begin
                if (!found && req[(m_last + i) % NCH]) begin
                    found = 1;
                    mg = (m_last + i) % NCH;
                end
            end
            gedge = cyc; m_last = mg; x_ack = 1 << mg;
        end
        for (int c = 0; c < NCH; c++)
            if (chan_clr[c]) begin m_integ[c] = 0; m_prev[c] = 0; end
        if (cfg_we && cfg_ch < NCH) begin
            case (cfg_sel)
                2'd0: m_kp[cfg_ch] = cfg_data;
                2'd1: m_ki[cfg_ch] = cfg_data;
                2'd2: m_kd[cfg_ch] = cfg_data;
                default: ;
            endcase
        end
        x_busy = (cyc >= gedge && cyc <= gedge + 2) ? 1 : 0;
    endtask

    always @(posedge clk) begin
        tb_cyc++;
        if (!rst_n) model_reset();
        else model_step();
        #1;
        check("ack", int'(ack), x_ack);
        check("out_valid", int'(out_valid), x_valid);
        check("busy", int'(busy), x_busy);
        check("out_ch", int'(out_ch), x_out_ch);
        check("out_data", int'(out_data), x_out_data);
        for (int c = 0; c < NCH; c++)
            check($sformatf("ctrl%0d", c), int'(ctrl[c*8 +: 8]), m_ctrl[c]);
    end

    task automatic cfg(input int ch, input int sel, input int data);
        cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_sel = 2'(sel); cfg_data = 8'(data);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < limit);
        check("valid_timeout", int'(out_valid), 1);
    endtask

    task automatic do_sample(input int ch, input int sp, input int fb,
                             output int data, output int aw, output int lat);
        setpoint[ch*8 +: 8] = 8'(sp);
        feedback[ch*8 +: 8] = 8'(fb);
        req[ch] = 1'b1;
        aw = 0;
        do begin @(negedge clk); aw++; end while (!ack[ch] && aw < 40);
        req[ch] = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 10);
        data = int'(out_data);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int data, aw, lat, prev_t;
        req = '0; setpoint = '0; feedback = '0; chan_clr = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", int'(ctrl), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin with all requests held from reset.
        req = '1;
        prev_t = 0;
        for (int n = 0; n < 5; n++) begin
            wait_valid(8);
            check("rr_order", int'(out_ch), n % NCH);
            if (n > 0) check("rr_spacing", tb_cyc - prev_t, 4);
            prev_t = tb_cyc;
        end
        req = '0;
        @(negedge clk);

        // Default gains: 100 - 40 -> 60, ack next cycle, result two later.
        do_sample(0, 100, 40, data, aw, lat);
        check("t1_data", data, 60);
        check("t1_ack_wait", aw, 1);
        check("t1_latency", lat, 2);
        check("t1_ctrl0", int'(ctrl[7:0]), 60);

        // Integral-only channel accumulates, then clears.
        cfg(1, 0, 0);
        cfg(1, 1, 2);
        for (int k = 1; k <= 3; k++) begin
            do_sample(1, 20, 10, data, aw, lat);
            check("t3_integ", data, 20 * k);
        end
        chan_clr[1] = 1'b1;
        @(negedge clk);
        chan_clr = '0;
        do_sample(1, 20, 10, data, aw, lat);
        check("t3_after_clr", data, 20);

        // Clamp both ends.
        cfg(2, 0, 255);
        do_sample(2, 255, 0, data, aw, lat);
        check("t4_hi", data, 255);
        do_sample(2, 0, 255, data, aw, lat);
        check("t4_lo", data, 0);

        // Integral saturation without wrap.
        cfg(3, 1, 255);
        for (int k = 0; k < 3; k++) begin
            do_sample(3, 255, 0, data, aw, lat);
            check("t5_sat_out", data, 255);
        end
        check("t5_model_integ", m_integ[3], 32767);

        // Ignored writes: select 3 and out-of-range channels.
        cfg(0, 3, 5);
        cfg(4, 0, 0);
        cfg(7, 1, 9);
        do_sample(0, 50, 40, data, aw, lat);
        check("t6_ignored_cfg", data, 10);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if (ack[c]) req[c] = 1'b0;
                else if (!req[c] && $urandom_range(3) == 0) req[c] = 1'b1;
                else if (req[c] && $urandom_range(49) == 0) req[c] = 1'b0;
            end
            setpoint = $urandom;
            feedback = $urandom;
            chan_clr = ($urandom_range(15) == 0) ? NCH'(1 << $urandom_range(NCH-1)) : '0;
            cfg_we   = ($urandom_range(7) == 0);
            cfg_ch   = 3'($urandom_range(7));
            cfg_sel  = 2'($urandom_range(3));
            cfg_data = ($urandom_range(1) == 1) ? 8'($urandom_range(3)) : 8'($urandom_range(255));
            @(negedge clk);
        end
        req = '0; chan_clr = '0; cfg_we = 1'b0;
        repeat (8) @(negedge clk);

        // Reset during COMPUTE aborts the sample and restores defaults.
        setpoint[15:8] = 8'd20;
        feedback[15:8] = 8'd10;
        req[1] = 1'b1;
        aw = 0;
        do begin @(negedge clk); aw++; end while (!ack[1] && aw < 40);
        check("rst_test_ack", int'(ack[1]), 1);
        req[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_valid", int'(out_valid), 0);
        check("async_busy", int'(busy), 0);
        check("async_ctrl", int'(ctrl), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        setpoint[7:0] = 8'd100;
        feedback[7:0] = 8'd40;
        req = 4'b0011;
        wait_valid(8);
        check("post_rst_ch", int'(out_ch), 0);
        check("post_rst_data0", int'(out_data), 60);
        wait_valid(8);
        req = '0;
        check("post_rst_ch1", int'(out_ch), 1);
        check("post_rst_data1", int'(out_data), 10);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
